// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with a word-serial refill.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   rdy              global stall; when low every register holds
//   clr              flush: cancels the response still owed to the fetch unit
//   addr, rn         fetch byte address (bits [17:2] used) and level-held request
//   Inst, Read_ready fetched word and its one-cycle valid pulse
//   mem_addr, mem_rn refill word address and read request toward memory
//   mem_data, mem_ready  refill word and its one-cycle valid pulse
//
// A hit is answered one cycle after the sampling edge and is followed by a
// one-cycle RESP bubble, so Read_ready can never be high on two adjacent
// cycles. A miss refills the whole line from word 0. The requested word is
// captured on the edge that accepts the last refill word, so DONE presents
// it without needing a second array read.
module icache #(
   parameter int LINE_COUNT     = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clr,
   input  logic [31:0] addr,
   input  logic        rn,
   output logic [31:0] Inst,
   output logic        Read_ready,
   output logic [31:0] mem_addr,
   output logic        mem_rn,
   input  logic [31:0] mem_data,
   input  logic        mem_ready
);

   localparam int OFF_W   = $clog2(WORDS_PER_LINE);
   localparam int IDX_W   = $clog2(LINE_COUNT);
   localparam int TAG_W   = 16 - OFF_W - IDX_W;
   localparam int IDX_LSB = 2 + OFF_W;
   localparam int TAG_LSB = 2 + OFF_W + IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
   localparam logic [OFF_W-1:0] ONE_WORD  = OFF_W'(1);

   typedef enum logic [1:0] {IDLE, RESP, REFILL, DONE} state_t;

   state_t            state_q, state_d;
   logic [15:0]       req_q, req_d;      // latched addr[17:2] of the missing fetch
   logic [OFF_W-1:0]  cnt_q, cnt_d;      // refill word counter
   logic              cancel_q, cancel_d;
   logic [31:0]       inst_q, inst_d;
   logic              rrdy_q, rrdy_d;
   logic [31:0]       maddr_q, maddr_d;
   logic              mrn_q, mrn_d;

   logic [LINE_COUNT-1:0] valid_q;
   logic [TAG_W-1:0]      tag_q  [LINE_COUNT];
   logic [31:0]           data_q [LINE_COUNT*WORDS_PER_LINE];

   logic                  fill_we, line_start, line_done;

   // Address fields of the live request and of the latched miss.
   logic [OFF_W-1:0] a_off, r_off;
   logic [IDX_W-1:0] a_idx, r_idx;
   logic [TAG_W-1:0] a_tag, r_tag;
   assign a_off = addr[2 +: OFF_W];
   assign a_idx = addr[IDX_LSB +: IDX_W];
   assign a_tag = addr[17:TAG_LSB];
   assign r_off = req_q[0 +: OFF_W];
   assign r_idx = req_q[OFF_W +: IDX_W];
   assign r_tag = req_q[15 -: TAG_W];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:18], addr[1:0]};

   logic hit;
   assign hit = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

   // Single read port: lookups in IDLE, requested-word fetch during REFILL.
   logic [IDX_W+OFF_W-1:0] rd_ptr;
   logic [31:0]            rd_word;
   assign rd_ptr  = (state_q == REFILL) ? {r_idx, r_off} : {a_idx, a_off};
   assign rd_word = data_q[rd_ptr];

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      cnt_d      = cnt_q;
      cancel_d   = cancel_q;
      inst_d     = inst_q;
      rrdy_d     = 1'b0;
      maddr_d    = maddr_q;
      mrn_d      = mrn_q;
      fill_we    = 1'b0;
      line_start = 1'b0;
      line_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rn && !clr) begin
               if (hit) begin
                  inst_d  = rd_word;
                  rrdy_d  = 1'b1;
                  state_d = RESP;
               end else begin
                  req_d      = addr[17:2];
                  cnt_d      = '0;
                  cancel_d   = 1'b0;
                  maddr_d    = {14'b0, a_tag, a_idx, {OFF_W{1'b0}}, 2'b00};
                  mrn_d      = 1'b1;
                  line_start = 1'b1;
                  state_d    = REFILL;
               end
            end
         end
         RESP:  state_d = IDLE;
         REFILL: begin
            if (clr) cancel_d = 1'b1;
            if (mem_ready) begin
               fill_we = 1'b1;
               cnt_d   = cnt_q + ONE_WORD;
               if (cnt_q == LAST_WORD) begin
                  line_done = 1'b1;
                  mrn_d     = 1'b0;
                  // The word arriving now is not yet in the array.
                  inst_d    = (r_off == cnt_q) ? mem_data : rd_word;
                  rrdy_d    = !(cancel_q || clr);
                  state_d   = DONE;
               end else begin
                  maddr_d = {14'b0, r_tag, r_idx, cnt_q + ONE_WORD, 2'b00};
               end
            end
         end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= '0;
         cnt_q    <= '0;
         cancel_q <= 1'b0;
         inst_q   <= '0;
         rrdy_q   <= 1'b0;
         maddr_q  <= '0;
         mrn_q    <= 1'b0;
         valid_q  <= '0;
      end else if (rdy) begin
         state_q  <= state_d;
         req_q    <= req_d;
         cnt_q    <= cnt_d;
         cancel_q <= cancel_d;
         inst_q   <= inst_d;
         rrdy_q   <= rrdy_d;
         maddr_q  <= maddr_d;
         mrn_q    <= mrn_d;
         // Victim line is invalid while its words are being overwritten.
         if (line_start) valid_q[a_idx] <= 1'b0;
         if (line_done)  valid_q[r_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy) begin
         if (fill_we)   data_q[{r_idx, cnt_q}] <= mem_data;
         if (line_done) tag_q[r_idx]           <= r_tag;
      end
   end

   assign Inst       = inst_q;
   assign Read_ready = rrdy_q;
   assign mem_addr   = maddr_q;
   assign mem_rn     = mrn_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache with a 2-cycle memory responder, a
// cache-contents model (valid/tag per index filled by accepted refill words)
// and a per-cycle compare process on Read_ready/Inst and mem_rn/mem_addr.
module tb_icache;

   logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0, rn = 1'b0;
   logic [31:0] addr = '0, mem_data = '0;
   logic        mem_ready = 1'b0;
   logic [31:0] Inst, mem_addr;
   logic        Read_ready, mem_rn;

   always #5 clk = ~clk;

   icache dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .addr(addr), .rn(rn),
      .Inst(Inst), .Read_ready(Read_ready), .mem_addr(mem_addr),
      .mem_rn(mem_rn), .mem_data(mem_data), .mem_ready(mem_ready)
   );

   int pass_cnt = 0, tot_cnt = 0;
   int rr_cnt = 0, words = 0, fill_cnt = 0;
   logic rr_prev = 1'b0;
   logic       mv [64];
   logic [7:0] mt [64];
   logic [31:0] acc_q [$];

   // Memory content: upper half is the inverted word address, lower half the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return {~w[15:0], w[15:0]};
   endfunction

   function automatic logic model_hit(input logic [31:0] a);
      return mv[a[9:4]] && (mt[a[9:4]] == a[17:10]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Memory: answers each outstanding mem_rn two cycles after seeing it.
   initial begin
      int lat;
      lat = -1;
      forever begin
         tick();
         mem_ready = 1'b0;
         if (!mem_rn || rst) lat = -1;
         else begin
            if (lat < 0) lat = 2; else lat--;
            if (lat == 0) begin
               mem_ready = 1'b1;
               mem_data  = memf(mem_addr);
               lat       = -1;
            end
         end
      end
   end

   // Compare process: outputs at negedge, inputs seen here are what the next edge samples.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < 64; i++) mv[i] = 1'b0;
            fill_cnt = 0;
            rr_prev  = 1'b0;
         end else begin
            if (Read_ready) begin
               chk("rr_gap", {31'b0, rr_prev}, 32'd0);
               chk("inst", Inst, memf(addr));
               rr_cnt++;
            end
            if (!mem_rn) fill_cnt = 0;
            else begin
               chk("mem_addr", mem_addr, {14'b0, addr[17:4], fill_cnt[1:0], 2'b00});
               if (mem_ready && rdy) begin
                  acc_q.push_back(mem_addr);
                  words++;
                  fill_cnt++;
                  if (fill_cnt == 4) begin
                     mv[addr[9:4]] = 1'b1;
                     mt[addr[9:4]] = addr[17:10];
                  end
               end
            end
            rr_prev = Read_ready;
         end
      end
   end

   task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] ins);
      logic exp_hit;
      int   w0;
      tick();
      exp_hit = model_hit(a);
      w0   = words;
      addr = a;
      rn   = 1'b1;
      lat  = 0;
      ins  = '0;
      for (int n = 1; n <= 200; n++) begin
         tick();
         if (Read_ready) begin
            lat = n;
            ins = Inst;
            break;
         end
      end
      rn = 1'b0;
      chk("latency", 32'(lat), exp_hit ? 32'd1 : 32'd13);
      chk("refill_words", 32'(words - w0), exp_hit ? 32'd0 : 32'd4);
   endtask

   initial begin
      int lat, w0, r0, n;
      logic [31:0] ins;
      logic [6:0]  pat;
      logic        chg;
      for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; mt[i] = '0; end

      // Reset state
      tick(); tick();
      chk("rst_rr",    {31'b0, Read_ready}, 32'd0);
      chk("rst_mem_rn", {31'b0, mem_rn}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_inst",  Inst, 32'd0);
      rst = 1'b0;

      // Cold miss
      acc_q.delete();
      fetch(32'h0000_1004, lat, ins);
      chk("cold_lat", 32'(lat), 32'd13);
      chk("cold_inst", ins, 32'hEFFB_1004);
      chk("cold_nwords", 32'(acc_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < acc_q.size(); i++)
         chk("cold_seq", acc_q[i], 32'h0000_1000 + 32'(4 * i));

      // Hit
      fetch(32'h0000_100C, lat, ins);
      chk("hit_lat", 32'(lat), 32'd1);
      chk("hit_inst", ins, 32'hEFF3_100C);
      chk("hit_mem_rn", {31'b0, mem_rn}, 32'd0);

      // Conflict: same index, new tag, then the old line misses again
      acc_q.delete();
      fetch(32'h0000_1404, lat, ins);
      chk("conf_lat", 32'(lat), 32'd13);
      chk("conf_inst", ins, 32'hEBFB_1404);
      if (acc_q.size() == 4) begin
         chk("conf_first", acc_q[0], 32'h0000_1400);
         chk("conf_last",  acc_q[3], 32'h0000_140C);
      end else chk("conf_nwords", 32'(acc_q.size()), 32'd4);
      fetch(32'h0000_1004, lat, ins);
      chk("conf_remiss_lat", 32'(lat), 32'd13);

      // Flush during the second refill wait
      tick();
      w0 = words; r0 = rr_cnt;
      addr = 32'h0000_2008; rn = 1'b1;
      n = 0;
      while (words - w0 < 1 && n < 100) begin tick(); n++; end
      clr = 1'b1; rn = 1'b0;
      tick();
      clr = 1'b0;
      n = 0;
      while (words - w0 < 4 && n < 100) begin tick(); n++; end
      repeat (3) tick();
      chk("flush_words", 32'(words - w0), 32'd4);
      chk("flush_rr", 32'(rr_cnt - r0), 32'd0);
      fetch(32'h0000_2008, lat, ins);
      chk("flush_hit_lat", 32'(lat), 32'd1);
      chk("flush_hit_inst", ins, 32'hDFF7_2008);

      // Back-to-back hits with rn held, addr stepping
      tick();
      addr = 32'h0000_2000; rn = 1'b1; pat = '0; chg = 1'b0;
      for (int k = 0; k < 7; k++) begin
         tick();
         pat = {pat[5:0], Read_ready};
         if (chg) begin addr = addr + 32'd4; chg = 1'b0; end
         if (Read_ready) chg = 1'b1;
      end
      rn = 1'b0;
      chk("b2b_pattern", {25'b0, pat}, 32'b1010101);

      // Reset after refill word 1
      tick();
      w0 = words;
      addr = 32'h0000_3004; rn = 1'b1;
      n = 0;
      while (words - w0 < 2 && n < 100) begin tick(); n++; end
      rst = 1'b1;
      tick();
      chk("rstmid_mem_rn", {31'b0, mem_rn}, 32'd0);
      chk("rstmid_rr", {31'b0, Read_ready}, 32'd0);
      rst = 1'b0; rn = 1'b0;
      repeat (2) tick();
      acc_q.delete();
      fetch(32'h0000_3004, lat, ins);
      chk("rstmid_lat", 32'(lat), 32'd13);
      chk("rstmid_first", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, 32'h0000_3000);

      // Stall: a hit is held off while rdy is low
      tick();
      addr = 32'h0000_3008; rn = 1'b1; rdy = 1'b0;
      repeat (3) begin
         tick();
         chk("stall_rr", {31'b0, Read_ready}, 32'd0);
      end
      rdy = 1'b1;
      tick();
      chk("stall_release_rr", {31'b0, Read_ready}, 32'd1);
      rn = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
